ir_reg: RTL and testbench

//   6502 instruction register. Captures the opcode byte from the data bus on
//   the opcode-fetch (SYNC) cycle and holds it stable until the next fetch.

---
 rtl/ir_pkg.sv | 32 +++
 rtl/ir_predecode.sv | 69 ++++++
 rtl/ir_reg.sv | 37 +++
 tb/tb_ir_reg.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types and constants for the 6502 instruction register and predecoder.
package ir_pkg;

  typedef enum logic [3:0] {
    IMPL = 4'd0,
    ACC  = 4'd1,
    IMM  = 4'd2,
    ZP   = 4'd3,
    ZPX  = 4'd4,
    ZPY  = 4'd5,
    ABS  = 4'd6,
    ABSX = 4'd7,
    ABSY = 4'd8,
    IND  = 4'd9,
    INDX = 4'd10,
    INDY = 4'd11,
    REL  = 4'd12
  } addr_mode_t;

  localparam logic [7:0] BRK_OPCODE = 8'h00;

  function automatic logic [1:0] mode_len(input addr_mode_t mode);
    logic [1:0] len;
    len = 2'd2;
    if (mode inside {IMPL, ACC})
      len = 2'd1;
    else if (mode inside {ABS, ABSX, ABSY, IND})
      len = 2'd3;
    return len;
  endfunction

endpackage

// File: rtl/ir_predecode.sv
// Combinational predecode of the latched opcode into addressing mode and length.
module ir_predecode
  import ir_pkg::*;
(
  input  logic [7:0]  ir,
  output addr_mode_t  addr_mode,
  output logic [1:0]  instr_len
);

  logic [2:0] aaa;
  logic [2:0] bbb;
  logic [1:0] cc;

  assign aaa = ir[7:5];
  assign bbb = ir[4:2];
  assign cc  = ir[1:0];

  always_comb begin
    addr_mode = IMPL;
    case (cc)
      2'b01: begin
        case (bbb)
          3'd0: addr_mode = INDX;
          3'd1: addr_mode = ZP;
          3'd2: addr_mode = IMM;
          3'd3: addr_mode = ABS;
          3'd4: addr_mode = INDY;
          3'd5: addr_mode = ZPX;
          3'd6: addr_mode = ABSY;
          default: addr_mode = ABSX;
        endcase
      end
      2'b10: begin
        case (bbb)
          3'd0: addr_mode = IMM;
          3'd1: addr_mode = ZP;
          3'd2: addr_mode = (aaa < 3'd4) ? ACC : IMPL;
          3'd3: addr_mode = ABS;
          // LDX/STX index through Y instead of X
          3'd5: addr_mode = (aaa == 3'd4 || aaa == 3'd5) ? ZPY : ZPX;
          3'd7: addr_mode = (aaa == 3'd5) ? ABSY : ABSX;
          default: addr_mode = IMPL;
        endcase
      end
      2'b00: begin
        case (bbb)
          3'd0: begin
            if (ir == 8'h20)
              addr_mode = ABS;
            else if (aaa < 3'd4)
              addr_mode = IMPL;
            else
              addr_mode = IMM;
          end
          3'd1: addr_mode = ZP;
          3'd3: addr_mode = (ir == 8'h6C) ? IND : ABS;
          3'd4: addr_mode = REL;
          3'd5: addr_mode = ZPX;
          3'd7: addr_mode = ABSX;
          default: addr_mode = IMPL;
        endcase
      end
      default: addr_mode = IMPL;
    endcase
  end

  assign instr_len = mode_len(addr_mode);

endmodule

// File: rtl/ir_reg.sv
// 6502 instruction register: latches the opcode on SYNC and exposes predecoded fields.
module ir_reg
  import ir_pkg::*;
#(
  parameter logic [7:0] RESET_OPCODE = BRK_OPCODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  input  logic        sync,
  input  logic        force_brk,
  output logic [7:0]  ir,
  output logic [2:0]  op_aaa,
  output logic [2:0]  op_bbb,
  output logic [1:0]  op_cc,
  output addr_mode_t  addr_mode,
  output logic [1:0]  instr_len
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ir <= RESET_OPCODE;
    else if (sync)
      ir <= force_brk ? BRK_OPCODE : data;
  end

  assign op_aaa = ir[7:5];
  assign op_bbb = ir[4:2];
  assign op_cc  = ir[1:0];

  ir_predecode u_predecode (
    .ir        (ir),
    .addr_mode (addr_mode),
    .instr_len (instr_len)
  );

endmodule

// File: tb/tb_ir_reg.sv
// Self-checking bench for ir_reg against an opcode-table reference model.
`timescale 1ns/1ps
module tb_ir_reg;
  import ir_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  data = 8'h00;
  logic        sync = 1'b0;
  logic        force_brk = 1'b0;
  logic [7:0]  ir;
  logic [2:0]  op_aaa;
  logic [2:0]  op_bbb;
  logic [1:0]  op_cc;
  addr_mode_t  addr_mode;
  logic [1:0]  instr_len;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_ir;

  ir_reg #(.RESET_OPCODE(8'h00)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data),
    .sync      (sync),
    .force_brk (force_brk),
    .ir        (ir),
    .op_aaa    (op_aaa),
    .op_bbb    (op_bbb),
    .op_cc     (op_cc),
    .addr_mode (addr_mode),
    .instr_len (instr_len)
  );

  always #10 clk = ~clk;

  // Reference: base mode per column group, then the documented per-opcode exceptions.
  function automatic addr_mode_t ref_mode(input logic [7:0] op);
    addr_mode_t g00 [8];
    addr_mode_t g01 [8];
    addr_mode_t g10 [8];
    addr_mode_t m;
    int unsigned a, b;
    g00 = '{IMM, ZP, IMPL, ABS, REL, ZPX, IMPL, ABSX};
    g01 = '{INDX, ZP, IMM, ABS, INDY, ZPX, ABSY, ABSX};
    g10 = '{IMM, ZP, IMPL, ABS, IMPL, ZPX, IMPL, ABSX};
    a = int'(op) / 32;
    b = (int'(op) / 4) % 8;
    m = IMPL;
    case (int'(op) % 4)
      0: begin
        m = g00[b];
        if (op == 8'h00 || op == 8'h40 || op == 8'h60) m = IMPL;
        if (op == 8'h20) m = ABS;
        if (op == 8'h6C) m = IND;
      end
      1: m = g01[b];
      2: begin
        m = g10[b];
        if (b == 2 && a < 4) m = ACC;
        if (b == 5 && (a == 4 || a == 5)) m = ZPY;
        if (b == 7 && a == 5) m = ABSY;
      end
      default: m = IMPL;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] ref_len(input addr_mode_t m);
    if (m == IMPL || m == ACC) return 2'd1;
    if (m == ABS || m == ABSX || m == ABSY || m == IND) return 2'd3;
    return 2'd2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    data = 8'h5A; sync = 1'b1; force_brk = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ir !== 8'h00) $display("FAIL reset_async: ir=%h expected 00", ir); else passed++;
    total++;
    if (addr_mode !== IMPL || instr_len !== 2'd1)
      $display("FAIL reset_decode: mode=%0d len=%0d expected %0d/1", addr_mode, instr_len, IMPL);
    else passed++;
    tick();
    total++;
    if (ir !== 8'h00) $display("FAIL reset_held: ir=%h expected 00", ir); else passed++;
    sync = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    total++;
    if (ir !== 8'h00) $display("FAIL reset_release_hold: ir=%h expected 00", ir); else passed++;
    exp_ir = 8'h00;
  endtask

  task automatic test_load_hold();
    sync = 1'b1; data = 8'h5A;
    tick();
    total++;
    if (ir !== 8'h5A) $display("FAIL load: ir=%h expected 5a", ir); else passed++;
    sync = 1'b0; data = 8'hA5;
    tick();
    tick();
    total++;
    if (ir !== 8'h5A) $display("FAIL hold: ir=%h expected 5a", ir); else passed++;
    exp_ir = 8'h5A;
  endtask

  task automatic test_imm();
    sync = 1'b1; data = 8'hA5;
    tick();
    data = 8'hA9;  // data changes must not reach decode until the next load
    #1;
    sync = 1'b0;
    total++;
    if (ir !== 8'hA5 || addr_mode !== ZP || instr_len !== 2'd2)
      $display("FAIL lda_zp: ir=%h mode=%0d len=%0d expected a5/%0d/2", ir, addr_mode, instr_len, ZP);
    else passed++;
    sync = 1'b1;
    tick();
    sync = 1'b0;
    total++;
    if (ir !== 8'hA9 || addr_mode !== IMM || instr_len !== 2'd2)
      $display("FAIL lda_imm: ir=%h mode=%0d len=%0d expected a9/%0d/2", ir, addr_mode, instr_len, IMM);
    else passed++;
    exp_ir = 8'hA9;
  endtask

  task automatic test_force_brk();
    sync = 1'b1; force_brk = 1'b1; data = 8'hAD;
    tick();
    total++;
    if (ir !== 8'h00) $display("FAIL force_brk_load: ir=%h expected 00", ir); else passed++;
    force_brk = 1'b0;
    tick();
    total++;
    if (ir !== 8'hAD) $display("FAIL reload_after_brk: ir=%h expected ad", ir); else passed++;
    sync = 1'b0; force_brk = 1'b1; data = 8'h11;
    tick();
    total++;
    if (ir !== 8'hAD) $display("FAIL force_brk_nosync: ir=%h expected ad", ir); else passed++;
    force_brk = 1'b0;
    exp_ir = 8'hAD;
  endtask

  task automatic test_decode_sweep();
    logic [7:0] ops [5];
    addr_mode_t modes [5];
    logic [1:0] lens [5];
    ops   = '{8'h6C, 8'hB6, 8'h0A, 8'hD0, 8'h20};
    modes = '{IND, ZPY, ACC, REL, ABS};
    lens  = '{2'd3, 2'd2, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 5; i++) begin
      sync = 1'b1; data = ops[i];
      tick();
      total++;
      if (ir !== ops[i] || addr_mode !== modes[i] || instr_len !== lens[i])
        $display("FAIL sweep_%h: ir=%h mode=%0d len=%0d expected mode %0d len %0d",
                 ops[i], ir, addr_mode, instr_len, modes[i], lens[i]);
      else passed++;
    end
    sync = 1'b0;
  endtask

  task automatic test_all_opcodes();
    for (int op = 0; op < 256; op++) begin
      addr_mode_t em;
      sync = 1'b1; data = 8'(op);
      tick();
      em = ref_mode(8'(op));
      total++;
      if (ir !== 8'(op) || {op_aaa, op_bbb, op_cc} !== 8'(op) ||
          addr_mode !== em || instr_len !== ref_len(em))
        $display("FAIL opcode_%h: ir=%h fields=%h mode=%0d len=%0d expected mode %0d len %0d",
                 op[7:0], ir, {op_aaa, op_bbb, op_cc}, addr_mode, instr_len, em, ref_len(em));
      else passed++;
    end
    sync = 1'b0;
    exp_ir = 8'hFF;
  endtask

  task automatic test_back_to_back();
    sync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data = 8'(8'h10 * (i + 3) + 5);
      tick();
    end
    sync = 1'b0;
    total++;
    if (ir !== 8'h65) $display("FAIL back_to_back: ir=%h expected 65", ir); else passed++;
    exp_ir = 8'h65;
  endtask

  task automatic test_async_reset();
    sync = 1'b1; data = 8'hA5;
    tick();
    sync = 1'b0;
    total++;
    if (ir !== 8'hA5) $display("FAIL pre_reset_load: ir=%h expected a5", ir); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ir !== 8'h00) $display("FAIL async_reset: ir=%h expected 00", ir); else passed++;
    #2 rst_n = 1'b1;
    data = 8'h77;
    tick();
    total++;
    if (ir !== 8'h00) $display("FAIL post_reset_nosync: ir=%h expected 00", ir); else passed++;
    sync = 1'b1;
    tick();
    sync = 1'b0;
    total++;
    if (ir !== 8'h77) $display("FAIL post_reset_load: ir=%h expected 77", ir); else passed++;
    exp_ir = 8'h77;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      addr_mode_t em;
      sync      = ($urandom_range(0, 1) == 1);
      force_brk = ($urandom_range(0, 3) == 0);
      data      = 8'($urandom);
      tick();
      if (sync) exp_ir = force_brk ? 8'h00 : data;
      em = ref_mode(exp_ir);
      total++;
      if (ir !== exp_ir || addr_mode !== em || instr_len !== ref_len(em))
        $display("FAIL random_%0d: ir=%h mode=%0d len=%0d expected %h/%0d/%0d",
                 n, ir, addr_mode, instr_len, exp_ir, em, ref_len(em));
      else passed++;
    end
    sync = 1'b0; force_brk = 1'b0;
  endtask

  initial begin
    exp_ir = 8'h00;
    test_reset();
    test_load_hold();
    test_imm();
    test_force_brk();
    test_decode_sweep();
    test_all_opcodes();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
